rx_frame_store_ctrl: RTL
========================

Name: rx_frame_store_ctrl

Overview:
- Sits directly after the serial message receiver and consumes its byte stream (msg byte, data-valid level, particle/map flags).
- Packs bytes into words and writes them into one shared single-port buffer RAM: particle region at the low addresses, map region directly above it.
- Arbitrates that RAM port between its own writes and read requests from the particle-filter core.
- Reports frame completion, word counts and framing errors.

Parameters:
- WORD_BYTES, 4, bytes per stored word; the first received byte goes to the MSBs.
- PARTICLE_WORDS, 64, size of the particle region in words; base address 0.
- MAP_WORDS, 256, size of the map region in words; base address PARTICLE_WORDS.
- ADDR_WIDTH, 9, RAM address width; must satisfy 2^ADDR_WIDTH >= PARTICLE_WORDS+MAP_WORDS.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- msg_in  in  8  received byte (receiver msg_out)
- msg_valid  in  1  receiver data_valid; a level that stays high for several cycles per byte
- particle_flag  in  1  receiver particle_data_flag
- map_flag  in  1  receiver map_data_flag
- mem_addr  out  ADDR_WIDTH  shared RAM address
- mem_wdata  out  8*WORD_BYTES  RAM write data
- mem_we  out  1  RAM write enable
- mem_re  out  1  RAM read enable
- mem_rdata  in  8*WORD_BYTES  RAM read data, valid 1 cycle after mem_re
- rd_req  in  1  consumer read request; held until granted
- rd_addr  in  ADDR_WIDTH  consumer read address
- rd_grant  out  1  read accepted this cycle (combinational)
- rd_data  out  8*WORD_BYTES  mem_rdata passthrough
- rd_data_valid  out  1  high 1 cycle after rd_grant
- particle_done  out  1  1-cycle pulse: particle frame stored cleanly
- map_done  out  1  1-cycle pulse: map frame stored cleanly
- word_count  out  ADDR_WIDTH  words stored in the last frame; updated with done or frame_error
- frame_error  out  1  1-cycle pulse: malformed frame

Behaviour:
- Reset: state IDLE. Counters, assembler, wr_pending, msg_valid edge register all clear. All outputs 0.
- Byte strobe: byte_stb = msg_valid & ~msg_valid_q. Exactly one byte is counted per msg_valid rising edge, regardless of how long the level stays high.
- State IDLE:
  - particle_flag & ~map_flag -> PARTICLE.
  - map_flag & ~particle_flag -> MAP.
  - Both high -> frame_error pulse next cycle, stay in IDLE.
  - Entering either state clears byte_cnt, word_idx and ovf.
- States PARTICLE / MAP:
  - On byte_stb: shift msg_in into the assembler and increment byte_cnt.
  - When byte_cnt reaches WORD_BYTES: next cycle latch wr_pending=1 with wr_addr = base+word_idx, increment word_idx, clear byte_cnt.
  - If word_idx == region size when a word completes: set sticky ovf, drop the word, generate no write.
  - The flag belonging to the current state deasserting -> DONE. The other flag rising mid-frame is ignored.
- State DONE:
  - Wait until wr_pending == 0. Then, for exactly 1 cycle: word_count <= word_idx.
  - If byte_cnt == 0 and ~ovf: pulse the done output for the current region.
  - Otherwise pulse frame_error.
  - Then go to IDLE.
- Arbitration, evaluated every cycle:
  - wr_pending has absolute priority: mem_we=1, mem_addr=wr_addr, mem_wdata=word, rd_grant=0; wr_pending clears the same cycle. The receiver cannot be stalled.
  - Otherwise, if rd_req and rd_addr is not inside the region currently being filled (PARTICLE/MAP/DONE states only): rd_grant=1, mem_re=1, mem_addr=rd_addr.
  - Reads from the other region, or any read while IDLE, are always grantable.
  - Out-of-range rd_addr (>= PARTICLE_WORDS+MAP_WORDS) is granted; the data is don't-care.
- rd_data_valid is a registered copy of rd_grant. rd_data = mem_rdata.
- Latency: the last byte_stb of a word -> mem_we 1 cycle later, assuming no write is already pending. Bytes arrive at least 3 cycles apart, so one pending slot is sufficient.
- Reset mid-frame: discard the partial word and any pending write; no done or error pulse; return to IDLE.

Test Plan:
- Particle frame, 8 bytes 0x01..0x08, msg_valid held 3 cycles per byte, WORD_BYTES=4 -> writes addr0=0x01020304 and addr1=0x05060708; particle_done pulse; word_count=2.
- Map frame, 4 bytes 0xAA,0xBB,0xCC,0xDD -> write addr 64 = 0xAABBCCDD; map_done pulse; word_count=1.
- Particle frame, 6 bytes -> one write at addr0; frame_error pulse; word_count=1; no particle_done.
- rd_req to addr 70 during a particle frame -> granted immediately, rd_data_valid the next cycle. rd_req to addr 1 -> held off until the frame completes. rd_req asserted in the same cycle as a pending write -> grant delayed exactly 1 cycle.
- Particle frame of 65 words (PARTICLE_WORDS=64) -> 64 writes (addr 0..63); 65th word dropped; frame_error; word_count=64.
- Reset asserted after 2 bytes, then a clean 4-byte map frame -> no write from the aborted frame; map write at addr 64; map_done.

Source files
------------

// File: rtl/rx_frame_store_ctrl.sv
// Packs receiver bytes into words, stores particle/map frames in a shared
// single-port RAM and arbitrates that port against consumer reads.
module rx_frame_store_ctrl #(
    parameter int WORD_BYTES     = 4,
    parameter int PARTICLE_WORDS = 64,
    parameter int MAP_WORDS      = 256,
    parameter int ADDR_WIDTH     = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              msg_in,
    input  logic                    msg_valid,
    input  logic                    particle_flag,
    input  logic                    map_flag,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [8*WORD_BYTES-1:0] mem_wdata,
    output logic                    mem_we,
    output logic                    mem_re,
    input  logic [8*WORD_BYTES-1:0] mem_rdata,
    input  logic                    rd_req,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic                    rd_grant,
    output logic [8*WORD_BYTES-1:0] rd_data,
    output logic                    rd_data_valid,
    output logic                    particle_done,
    output logic                    map_done,
    output logic [ADDR_WIDTH-1:0]   word_count,
    output logic                    frame_error
);

    localparam int W  = 8 * WORD_BYTES;
    localparam int CW = $clog2(WORD_BYTES + 1);
    localparam int XW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] MAP_BASE = ADDR_WIDTH'(PARTICLE_WORDS);
    localparam logic [XW-1:0] P_END_X   = XW'(PARTICLE_WORDS);
    localparam logic [XW-1:0] M_END_X   = XW'(PARTICLE_WORDS + MAP_WORDS);
    localparam logic [XW-1:0] P_WORDS_X = XW'(PARTICLE_WORDS);
    localparam logic [XW-1:0] M_WORDS_X = XW'(MAP_WORDS);

    typedef enum logic [1:0] {IDLE, PARTICLE, MAP, DONE} state_t;

    state_t                state, state_n;
    logic                  msg_valid_q;
    logic                  byte_stb;
    logic [CW-1:0]         byte_cnt;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  ovf;
    logic                  cur_map;
    logic [W-1:0]          asm_word;
    logic                  wr_pending;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [XW-1:0]         rd_addr_x;
    logic                  rd_blocked;
    logic                  region_full;

    assign byte_stb    = msg_valid & ~msg_valid_q;
    assign rd_addr_x   = {1'b0, rd_addr};
    assign region_full = {1'b0, word_idx} == (cur_map ? M_WORDS_X : P_WORDS_X);
    assign rd_data     = mem_rdata;

    // Only the region currently being filled is fenced off from readers.
    assign rd_blocked = (state != IDLE) &&
                        (cur_map ? (rd_addr_x >= P_END_X && rd_addr_x < M_END_X)
                                 : (rd_addr_x < P_END_X));

    always_comb begin
        state_n   = state;
        rd_grant  = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state)
            IDLE: begin
                if (particle_flag & ~map_flag)      state_n = PARTICLE;
                else if (map_flag & ~particle_flag) state_n = MAP;
            end
            PARTICLE: if (~particle_flag) state_n = DONE;
            MAP:      if (~map_flag)      state_n = DONE;
            DONE:     if (~wr_pending)    state_n = IDLE;
            default:  state_n = IDLE;
        endcase
        // The receiver cannot be stalled, so a pending write always wins.
        if (wr_pending) begin
            mem_we    = 1'b1;
            mem_addr  = wr_addr;
            mem_wdata = asm_word;
        end else if (rd_req && !rd_blocked) begin
            rd_grant = 1'b1;
            mem_re   = 1'b1;
            mem_addr = rd_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            msg_valid_q   <= 1'b0;
            byte_cnt      <= '0;
            word_idx      <= '0;
            ovf           <= 1'b0;
            cur_map       <= 1'b0;
            asm_word      <= '0;
            wr_pending    <= 1'b0;
            wr_addr       <= '0;
            rd_data_valid <= 1'b0;
            particle_done <= 1'b0;
            map_done      <= 1'b0;
            frame_error   <= 1'b0;
            word_count    <= '0;
        end else begin
            state         <= state_n;
            msg_valid_q   <= msg_valid;
            rd_data_valid <= rd_grant;
            wr_pending    <= 1'b0;
            particle_done <= 1'b0;
            map_done      <= 1'b0;
            frame_error   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (particle_flag & map_flag) begin
                        frame_error <= 1'b1;
                        word_count  <= '0;
                    end
                    if (state_n != IDLE) begin
                        byte_cnt <= '0;
                        word_idx <= '0;
                        ovf      <= 1'b0;
                        cur_map  <= map_flag;
                    end
                end
                PARTICLE, MAP: begin
                    if (byte_stb) begin
                        asm_word <= (asm_word << 8) | W'(msg_in);
                        if (byte_cnt == CW'(WORD_BYTES - 1)) begin
                            byte_cnt <= '0;
                            if (region_full) begin
                                ovf <= 1'b1;
                            end else begin
                                wr_pending <= 1'b1;
                                wr_addr    <= (cur_map ? MAP_BASE : '0) + word_idx;
                                word_idx   <= word_idx + 1'b1;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!wr_pending) begin
                        word_count <= word_idx;
                        if (byte_cnt == '0 && !ovf) begin
                            particle_done <= ~cur_map;
                            map_done      <= cur_map;
                        end else begin
                            frame_error <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
